// File: rtl/inst_encoder_pkg.sv
// Shared encoder types: request kinds, RV32 opcodes, encode and legality helpers.
// Macro RV32M_EN: when defined, R-kind funct7=0000001 (MUL..REMU) is accepted.
package EncoderTypes;

    typedef enum logic [3:0] {
        ENC_R,
        ENC_I,
        ENC_LD,
        ENC_ST,
        ENC_B,
        ENC_LUI,
        ENC_AUIPC,
        ENC_JAL,
        ENC_JALR
    } EncKind;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [31:0] enc_word(
        input EncKind      kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            ENC_R:     w = {f7, rs2, rs1, f3, rd, OPC_OP};
            ENC_I:     w = (f3 == 3'b001 || f3 == 3'b101)
                           ? {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM}
                           : {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
            ENC_LD:    w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            ENC_ST:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            ENC_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            ENC_LUI:   w = {imm[31:12], rd, OPC_LUI};
            ENC_AUIPC: w = {imm[31:12], rd, OPC_AUIPC};
            ENC_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            ENC_JALR:  w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            default:   w = '0;
        endcase
        return w;
    endfunction

    function automatic logic enc_legal(
        input EncKind      kind,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic fits12, fits13, fits21, shift, ok;
        // Sign-extended immediates fit N bits when everything above bit N-2 is a copy of the sign.
        fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
        fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
        fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
        shift  = (f3 == 3'b001) || (f3 == 3'b101);
        ok     = 1'b0;
        case (kind)
            ENC_R: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
`ifdef RV32M_EN
                ok = ok || (f7 == 7'h01);
`endif
            end
            ENC_I: begin
                if (shift)
                    ok = fits12 && (imm[11:5] == '0) &&
                         (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
                else
                    ok = fits12;
            end
            ENC_LD:    ok = fits12 && !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            ENC_ST:    ok = fits12 && (f3 <= 3'b010);
            ENC_B:     ok = fits13 && !imm[0] && (f3 != 3'b010) && (f3 != 3'b011);
            ENC_LUI:   ok = (imm[11:0] == '0);
            ENC_AUIPC: ok = (imm[11:0] == '0);
            ENC_JAL:   ok = fits21 && !imm[0];
            ENC_JALR:  ok = fits12 && (f3 == 3'b000);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Generic 2-entry FIFO; head is presented directly from storage.
// Latency: push in cycle N is visible at the head in N+1.
// Backpressure: pushes while full are dropped; the producer gates on count.
module inst_encoder_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign out_vld = (count != 2'd0);
    assign out_dat = mem[rd_ptr];
    assign do_pop  = out_vld & out_rdy;
    assign do_push = in_vld & (count != 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I/M field-to-word encoder with sequential IMEM addresses (RV32M_EN enables MUL..REMU).
// Latency: legal accept in cycle N presents the word in N+1; one word per cycle sustained.
// Backpressure: 2-entry output FIFO; reqReady drops when full or while start is asserted.
module inst_encoder
    import EncoderTypes::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  EncKind                reqKind,
    input  logic [4:0]            reqRd,
    input  logic [4:0]            reqRs1,
    input  logic [4:0]            reqRs2,
    input  logic [2:0]            reqFunct3,
    input  logic [6:0]            reqFunct7,
    input  logic [31:0]           reqImm,
    output logic                  instValid,
    input  logic                  instReady,
    output logic [31:0]           instData,
    output logic [ADDR_WIDTH-1:0] instAddr,
    output logic                  illegal,
    output logic [7:0]            errCount
);

    localparam int FW = 32 + ADDR_WIDTH;

    logic [1:0]            fifo_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  accept;
    logic                  legal;
    logic                  push;
    logic [31:0]           word;
    logic [FW-1:0]         head;

    // Ready is a function of the registered count only, so a pop while full frees space next cycle.
    assign reqReady = (fifo_cnt != 2'd2) & ~start;
    assign accept   = reqValid & reqReady;
    assign legal    = enc_legal(reqKind, reqFunct3, reqFunct7, reqImm);
    assign word     = enc_word(reqKind, reqRd, reqRs1, reqRs2, reqFunct3, reqFunct7, reqImm);
    assign push     = accept & legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt <= '0;
            illegal  <= 1'b0;
            errCount <= 8'd0;
        end else begin
            if (start)
                addr_cnt <= startAddr & ~ADDR_WIDTH'(3);
            else if (push)
                addr_cnt <= addr_cnt + ADDR_WIDTH'(4);
            illegal <= accept & ~legal;
            if (accept && !legal && errCount != 8'hff)
                errCount <= errCount + 8'd1;
        end
    end

    inst_encoder_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push),
        .in_dat  ({word, addr_cnt}),
        .out_vld (instValid),
        .out_rdy (instReady),
        .out_dat (head),
        .count   (fifo_cnt)
    );

    assign instData = head[FW-1:ADDR_WIDTH];
    assign instAddr = head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: arithmetic reference model, queue-based output monitor.
module tb_inst_encoder;
    import EncoderTypes::*;

`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] startAddr;
    logic        reqValid;
    logic        reqReady;
    EncKind      reqKind;
    logic [4:0]  reqRd, reqRs1, reqRs2;
    logic [2:0]  reqFunct3;
    logic [6:0]  reqFunct7;
    logic [31:0] reqImm;
    logic        instValid;
    logic        instReady;
    logic [31:0] instData;
    logic [31:0] instAddr;
    logic        illegal;
    logic [7:0]  errCount;

    int total = 0;
    int bad   = 0;

    logic [63:0] q[$];
    logic [63:0] seen[$];
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .startAddr (startAddr),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqKind   (reqKind),
        .reqRd     (reqRd),
        .reqRs1    (reqRs1),
        .reqRs2    (reqRs2),
        .reqFunct3 (reqFunct3),
        .reqFunct7 (reqFunct7),
        .reqImm    (reqImm),
        .instValid (instValid),
        .instReady (instReady),
        .instData  (instData),
        .instAddr  (instAddr),
        .illegal   (illegal),
        .errCount  (errCount)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: legality from plain integer ranges, words from shifted fields.
    function automatic bit ref_legal(input EncKind k, input int f3, input int f7, input logic [31:0] u);
        int s;
        s = $signed(u);
        case (k)
            ENC_R:     return f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (M_EN && f7 == 1);
            ENC_I:     if (f3 == 1 || f3 == 5)
                           return s >= 0 && s < 32 && (f7 == 0 || (f7 == 32 && f3 == 5));
                       else
                           return s >= -2048 && s <= 2047;
            ENC_LD:    return s >= -2048 && s <= 2047 && f3 != 3 && f3 != 6 && f3 != 7;
            ENC_ST:    return s >= -2048 && s <= 2047 && f3 <= 2;
            ENC_B:     return s >= -4096 && s <= 4095 && (s % 2 == 0) && f3 != 2 && f3 != 3;
            ENC_LUI:   return (u % 4096) == 0;
            ENC_AUIPC: return (u % 4096) == 0;
            ENC_JAL:   return s >= -1048576 && s <= 1048575 && (s % 2 == 0);
            ENC_JALR:  return s >= -2048 && s <= 2047 && f3 == 0;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input EncKind k, input int rd, input int rs1, input int rs2,
                                             input int f3, input int f7, input logic [31:0] u);
        logic [31:0] regs;
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        case (k)
            ENC_R:     return (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
            ENC_I:     if (f3 == 1 || f3 == 5)
                           return (32'(f7) << 25) | ((u & 32'h1f) << 20) | regs | (32'(rd) << 7) | 32'h13;
                       else
                           return ((u & 32'hfff) << 20) | regs | (32'(rd) << 7) | 32'h13;
            ENC_LD:    return ((u & 32'hfff) << 20) | regs | (32'(rd) << 7) | 32'h03;
            ENC_ST:    return (((u >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | regs
                              | ((u & 32'h1f) << 7) | 32'h23;
            ENC_B:     return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(rs2) << 20)
                              | regs | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            ENC_LUI:   return (u & 32'hfffff000) | (32'(rd) << 7) | 32'h37;
            ENC_AUIPC: return (u & 32'hfffff000) | (32'(rd) << 7) | 32'h17;
            ENC_JAL:   return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
                              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12)
                              | (32'(rd) << 7) | 32'h6f;
            ENC_JALR:  return ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
            default:   return 32'h0;
        endcase
    endfunction

    // Request-side model: predicts handshake, FIFO occupancy, addresses and error reporting.
    int m_cnt = 0, m_err = 0;
    logic [31:0] m_addr = 0;
    bit ill_exp = 1'b0;
    always @(negedge clk) begin
        bit exp_rdy, acc, lg, pop;
        if (!rst) begin
            q.delete();
            m_cnt = 0; m_err = 0; m_addr = 0; ill_exp = 1'b0;
        end else begin
            chk("illegal_pulse", 64'(illegal), 64'(ill_exp));
            chk("err_count", 64'(errCount), 64'(m_err));
            chk("inst_valid", 64'(instValid), 64'(m_cnt != 0));
            exp_rdy = (m_cnt != 2) && !start;
            chk("req_ready", 64'(reqReady), 64'(exp_rdy));
            acc = reqValid && exp_rdy;
            lg  = ref_legal(reqKind, int'(reqFunct3), int'(reqFunct7), reqImm);
            pop = (m_cnt != 0) && instReady;
            if (acc && lg)
                q.push_back({ref_word(reqKind, int'(reqRd), int'(reqRs1), int'(reqRs2),
                                      int'(reqFunct3), int'(reqFunct7), reqImm), m_addr});
            if (start) m_addr = startAddr & ~32'd3;
            else if (acc && lg) m_addr = m_addr + 32'd4;
            if (acc && !lg && m_err < 255) m_err++;
            m_cnt = m_cnt + int'(acc && lg) - int'(pop);
            ill_exp = acc && !lg;
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks head stability under stall.
    bit stall_prev = 1'b0;
    logic [31:0] prev_dat, prev_addr;
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("head_stable_data", 64'(instData), 64'(prev_dat));
                chk("head_stable_addr", 64'(instAddr), 64'(prev_addr));
            end
            if (instValid && instReady) begin
                chk("output_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("inst_data", 64'(instData), 64'(e[63:32]));
                    chk("inst_addr", 64'(instAddr), 64'(e[31:0]));
                end
                seen.push_back({instData, instAddr});
            end
            stall_prev = instValid && !instReady;
            prev_dat   = instData;
            prev_addr  = instAddr;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 instReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input EncKind k, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input logic [31:0] imm);
        bit ok;
        reqKind = k; reqRd = 5'(rd); reqRs1 = 5'(rs1); reqRs2 = 5'(rs2);
        reqFunct3 = 3'(f3); reqFunct7 = 7'(f7); reqImm = imm;
        reqValid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = reqReady;
        end
        chk("send_accepted_in_time", 64'(ok), 64'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] a);
        startAddr = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_seen(input int idx, input logic [31:0] d, input logic [31:0] a);
        if (idx < seen.size()) begin
            chk("seen_data", 64'(seen[idx][63:32]), 64'(d));
            chk("seen_addr", 64'(seen[idx][31:0]), 64'(a));
        end else begin
            chk("seen_count", 64'(seen.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        logic [31:0] nxt;
        int base;
        rst = 1'b1; start = 1'b0; startAddr = '0; reqValid = 1'b0; instReady = 1'b1;
        reqKind = ENC_R; reqRd = '0; reqRs1 = '0; reqRs2 = '0;
        reqFunct3 = '0; reqFunct7 = '0; reqImm = '0;
        #2 rst = 1'b0;
        #5;
        chk("rst_req_ready", 64'(reqReady), 64'd1);
        chk("rst_inst_valid", 64'(instValid), 64'd0);
        chk("rst_inst_data", 64'(instData), 64'd0);
        chk("rst_inst_addr", 64'(instAddr), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_err_count", 64'(errCount), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        seen.delete();
        send(ENC_I, 1, 0, 0, 0, 0, 32'd5);
        idle(2);
        expect_seen(0, 32'h00500093, 32'h0);

        pulse_start(32'h0);
        seen.delete();
        send(ENC_R, 3, 1, 2, 0, 7'h00, 32'd0);
        send(ENC_R, 3, 1, 2, 0, 7'h20, 32'd0);
        idle(2);
        expect_seen(0, 32'h002081B3, 32'h0);
        expect_seen(1, 32'h402081B3, 32'h4);

        seen.delete();
        send(ENC_B, 0, 1, 2, 0, 0, 32'd8);
        send(ENC_JAL, 1, 0, 0, 0, 0, 32'd8);
        idle(2);
        expect_seen(0, 32'h00208463, 32'h8);
        expect_seen(1, 32'h008000EF, 32'hC);

        seen.delete();
        send(ENC_R, 3, 1, 2, 0, 7'h01, 32'd0);
        idle(2);
`ifdef RV32M_EN
        expect_seen(0, 32'h022081B3, 32'h10);
        nxt = 32'h14;
`else
        chk("mul_no_output", 64'(seen.size()), 64'd0);
        chk("mul_err_count", 64'(errCount), 64'd1);
        nxt = 32'h10;
`endif
        base = seen.size();
        send(ENC_I, 1, 0, 0, 0, 0, 32'd5);
        idle(2);
        expect_seen(base, 32'h00500093, nxt);
        nxt = nxt + 32'd4;

        instReady = 1'b0;
        seen.delete();
        fork
            begin
                send(ENC_I, 1, 0, 0, 0, 0, 32'd1);
                send(ENC_I, 1, 0, 0, 0, 0, 32'd2);
                send(ENC_I, 1, 0, 0, 0, 0, 32'd3);
            end
            begin
                repeat (4) @(negedge clk);
                chk("full_req_ready", 64'(reqReady), 64'd0);
                chk("full_head_addr", 64'(instAddr), 64'(nxt));
                @(posedge clk);
                #1 instReady = 1'b1;
            end
        join
        idle(3);
        expect_seen(0, 32'h00100093, nxt);
        expect_seen(1, 32'h00200093, nxt + 32'd4);
        expect_seen(2, 32'h00300093, nxt + 32'd8);

        pulse_start(32'hFFFFFFFC);
        seen.delete();
        send(ENC_I, 1, 0, 0, 0, 0, 32'd7);
        send(ENC_I, 1, 0, 0, 0, 0, 32'd9);
        send(ENC_I, 1, 0, 0, 0, 0, 32'd2048);
        idle(2);
        expect_seen(0, 32'h00700093, 32'hFFFFFFFC);
        expect_seen(1, 32'h00900093, 32'h0);
        chk("wrap_seen_count", 64'(seen.size()), 64'd2);
        chk("imm2048_err_count", 64'(errCount), M_EN ? 64'd1 : 64'd2);

        seen.delete();
        startAddr = 32'h100; start = 1'b1;
        reqKind = ENC_I; reqRd = 5'd1; reqRs1 = '0; reqFunct3 = '0; reqFunct7 = '0; reqImm = 32'd1;
        reqValid = 1'b1;
        @(negedge clk);
        chk("start_blocks_req", 64'(reqReady), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; reqValid = 1'b0;
        idle(2);
        chk("start_no_output", 64'(seen.size()), 64'd0);
        send(ENC_I, 1, 0, 0, 0, 0, 32'd1);
        idle(2);
        expect_seen(0, 32'h00100093, 32'h100);

        rand_rdy = 1'b1;
        repeat (600) begin
            int ksel, f7sel, isel;
            logic [31:0] imm;
            int f7;
            if ($urandom_range(0, 30) == 0) pulse_start($urandom);
            ksel  = $urandom_range(0, 8);
            f7sel = $urandom_range(0, 3);
            isel  = $urandom_range(0, 5);
            case (f7sel)
                0: f7 = 0;
                1: f7 = 32;
                2: f7 = 1;
                default: f7 = $urandom_range(0, 127);
            endcase
            case (isel)
                0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: imm = 32'($urandom_range(0, 31));
                2: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
                3: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
                4: imm = $urandom & 32'hfffff000;
                default: imm = $urandom;
            endcase
            send(EncKind'(ksel), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), f7, imm);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_rdy = 1'b0;
        idle(1);
        instReady = 1'b1;
        idle(4);

        repeat (260) send(ENC_I, 1, 0, 0, 0, 0, 32'd2048);
        idle(2);
        chk("err_count_saturated", 64'(errCount), 64'd255);

        instReady = 1'b0;
        send(ENC_I, 2, 0, 0, 0, 0, 32'd4);
        send(ENC_I, 2, 0, 0, 0, 0, 32'd6);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(instValid), 64'd0);
        chk("async_rst_ready", 64'(reqReady), 64'd1);
        chk("async_rst_data", 64'(instData), 64'd0);
        chk("async_rst_err", 64'(errCount), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        instReady = 1'b1;
        seen.delete();
        send(ENC_I, 1, 0, 0, 0, 0, 32'd3);
        idle(2);
        expect_seen(0, 32'h00300093, 32'h0);

        idle(3);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I/M instruction encoder, the inverse of the decode stage: it takes field-level encode requests (kind, registers, funct3/funct7, immediate) and emits 32-bit instruction words, each tagged with a sequential word address for writing instruction memory. It is used by the boot/self-test loader and by benches to build programs in IMEM. It checks that every field is legal and encodable, drops illegal requests with an error report, and buffers its output in a 2-entry FIFO behind a valid/ready handshake.

## Interface
- `ADDR_WIDTH`, default 32: width of the instruction address counter.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: loads the address counter from `startAddr`.
- `startAddr  in  ADDR_WIDTH`: new base address; bits [1:0] are ignored and treated as 0.
- `reqValid  in  1`: encode request valid.
- `reqReady  out  1`: encoder can accept a request.
- `reqKind  in  EncKind`: instruction kind; one of ENC_R, ENC_I, ENC_LD, ENC_ST, ENC_B, ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_JALR.
- `reqRd`, `reqRs1`, `reqRs2`  in  5 each: register addresses.
- `reqFunct3  in  3`, `reqFunct7  in  7`: function fields.
- `reqImm  in  32`: immediate, given as its sign-extended value.
- `instValid  out  1`: encoded word available.
- `instReady  in  1`: consumer accepts the word.
- `instData  out  32`: encoded instruction.
- `instAddr  out  ADDR_WIDTH`: address of `instData`.
- `illegal  out  1`: one-cycle pulse reporting a rejected request.
- `errCount  out  8`: count of rejected requests; saturates at 255.

## Operation
- A request is accepted when `reqValid & reqReady`.
- `reqReady = (fifoCount != 2) & ~start`.
- Legality check and encoding are combinational on the request fields. Result is registered into the FIFO tail.
- Encodings (opcode in [6:0]):
  - R: {f7,rs2,rs1,f3,rd,0110011}.
  - I: {imm[11:0],rs1,f3,rd,0010011}. For f3=001/101 the form is {f7,imm[4:0],rs1,f3,rd,0010011}.
  - LD: as I with opcode 0000011.
  - ST: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}.
  - LUI: {imm[31:12],rd,0110111}. AUIPC: same with opcode 0010111.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
  - JALR: {imm[11:0],rs1,000,rd,1100111}.
- A request is illegal if any of the following holds:
  - I/LD/ST/JALR: imm is not representable as a 12-bit signed value.
  - B: imm is not 13-bit signed, or imm[0]=1.
  - JAL: imm is not 21-bit signed, or imm[0]=1.
  - LUI/AUIPC: imm[11:0]≠0.
  - B: f3 is 010 or 011.
  - LD: f3 is 011, 110 or 111.
  - ST: f3 > 010.
  - JALR: f3≠000.
  - I shifts: f7 is not 0000000 or 0100000; f7=0100000 with f3=001; or imm[11:5]≠0.
  - R: f7 is not 0000000, 0100000 or (M only) 0000001; f7=0100000 with f3 not 000/101.
- Illegal requests are consumed: no FIFO push and no address increment. `illegal` pulses the next cycle and `errCount` increments, saturating at 255.
- Each legal accept pushes {word, addrCnt} into the FIFO, then `addrCnt += 4`, wrapping modulo 2^ADDR_WIDTH.
- `start` loads `addrCnt` from `startAddr`. It does not affect entries already in the FIFO.

## Timing
- Reset values: `reqReady`=1, `instValid`=0, `instData`=0, `instAddr`=0, `illegal`=0, `errCount`=0, `addrCnt`=0, FIFO empty.
- Latency: accept in cycle N gives `instValid` in N+1. Sustained throughput is one word per cycle while `instReady`=1.
- `instData`/`instAddr` are the FIFO head. They stay stable while `instValid & ~instReady`.
- Push and pop in the same cycle with count 1 or 2: count unchanged, order preserved.
- Full (count=2): `reqReady`=0. A pop in that cycle does not raise `reqReady` until the next cycle.
- `start` and `reqValid` together: `start` wins and the request is not accepted.
- Reset asserted mid-stream flushes the FIFO immediately (asynchronous).

## Configuration
- `RV32M_EN` defined: R-kind with f7=0000001 is legal for every f3 (MUL…REMU).
- `RV32M_EN` undefined: R-kind with f7=0000001 is illegal.

## Structure
- Shared package (`EncoderTypes`): `EncKind` enum and the RV32 opcode constants, reused from the existing opcode definitions where present.
- Sub-module `inst_encoder_fifo`: 2-entry FIFO, data width 32+ADDR_WIDTH.
- Encode and legality check are functions in the package.

## Test plan
- ENC_I rd=1 rs1=0 f3=000 imm=5 after reset → `instData`=0x00500093, `instAddr`=0x0 one cycle later.
- ENC_R x3,x1,x2 with f7=0000000 then f7=0100000, back to back, instReady=1 → 0x002081B3 at addr 0, then 0x402081B3 at addr 4.
- ENC_B BEQ x1,x2,+8 → 0x00208463. ENC_JAL rd=1 imm=8 → 0x008000EF.
- ENC_R f7=0000001 (MUL x3,x1,x2) → with `RV32M_EN`: 0x022081B3; without: `illegal` pulse, `errCount`=1, no output, addr not advanced.
- instReady=0, three back-to-back requests → two accepted, `reqReady`=0, head stable. Release instReady → third accepted, addresses sequential.
- start with startAddr=0xFFFFFFFC, two requests → addrs 0xFFFFFFFC, then 0x00000000. Also ENC_I with imm=2048 → `illegal`.
